// File: rtl/jpeg_color_pkg.sv
// jpeg_color_pkg
// Shared colour-conversion constants for the JPEG datapath. Both the forward
// (RGB -> YCbCr) converter and the inverse (YCbCr -> RGB) converter take
// their coefficients from here so the two directions cannot drift apart.
//
// Contents:
//   FRAC_BITS_DEF  default fixed-point fraction bits (coefficients are x1024)
//   CRV/CGU/CGV/CBU inverse coefficients
//   FWD_*          forward coefficients, one row per output component
//   sum_t/prod_t   datapath types for the inverse pipeline
//   decode_y/sext8 helpers for the level-shifted byte format
package jpeg_color_pkg;

    localparam int FRAC_BITS_DEF = 10;

    // Inverse (YCbCr -> RGB) coefficients, x1024
    localparam int CRV = 1613;
    localparam int CGU = 192;
    localparam int CGV = 479;
    localparam int CBU = 1900;

    // Forward (RGB -> YCbCr) coefficients, x1024, magnitudes per row
    localparam int FWD_Y_R  = 218;
    localparam int FWD_Y_G  = 732;
    localparam int FWD_Y_B  = 74;
    localparam int FWD_CB_R = 117;
    localparam int FWD_CB_G = 395;
    localparam int FWD_CB_B = 512;
    localparam int FWD_CR_R = 512;
    localparam int FWD_CR_G = 465;
    localparam int FWD_CR_B = 47;

    // 21 bits signed holds every intermediate (-243200 .. ~+502k)
    localparam int SUM_W = 21;

    typedef logic signed [SUM_W-1:0] sum_t;

    // Stage-1 register contents: the shifted luma and the four products
    typedef struct packed {
        sum_t y_sh;
        sum_t crv_v;
        sum_t cgu_u;
        sum_t cgv_v;
        sum_t cbu_u;
    } prod_t;

    // Each forward row weights three components that sum to 1.0 (1024);
    // handy as an elaboration-time sanity check in the forward converter.
    function automatic int fwd_row_sum(input int row);
        case (row)
            0:       return FWD_Y_R + FWD_Y_G + FWD_Y_B;
            1:       return FWD_CB_R + FWD_CB_G + FWD_CB_B;
            default: return FWD_CR_R + FWD_CR_G + FWD_CR_B;
        endcase
    endfunction

    // Level-shifted luma byte back to unsigned 0..255: flip the MSB
    function automatic logic [7:0] decode_y(input logic [7:0] ys);
        return {~ys[7], ys[6:0]};
    endfunction

    // Sign-extend a two's-complement chroma byte to the datapath width
    function automatic sum_t sext8(input logic [7:0] b);
        return {{(SUM_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/yuv_clip8.sv
// yuv_clip8
// Final scaling of one colour channel: arithmetic shift right by FRAC_BITS
// (floor), then clamp to 0..255. Purely combinational; the caller registers.
//
// Ports:
//   sum      in  21  signed fixed-point channel value (rounding already added)
//   pix      out 8   clamped unsigned channel value
//   clipped  out 1   high when the clamp changed the value
module yuv_clip8
    import jpeg_color_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  sum_t       sum,
    output logic [7:0] pix,
    output logic       clipped
);

    sum_t shifted;

    assign shifted = sum >>> FRAC_BITS;

    always_comb begin
        pix     = shifted[7:0];
        clipped = 1'b0;
        if (shifted < 0) begin
            pix     = 8'h00;
            clipped = 1'b1;
        end else if (shifted > sum_t'(255)) begin
            pix     = 8'hFF;
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/yuv2rgb.sv
// yuv2rgb
// Inverse colour-space converter: level-shifted BT.709 full-range YCbCr
// (JPEG encoder internal format) to 8-bit RGB. Three pipeline stages with a
// valid/ready handshake on both sides and a saturating count of clipped
// output components.
//
//   stage 1: decode bytes, register Y<<10 and the four coefficient products
//   stage 2: register the three rounded 21-bit signed channel sums
//   stage 3: shift/clamp each channel, register into pixel_data_out
//
// Ports:
//   clk              in   1      clock
//   rst              in   1      synchronous reset, active high
//   pixel_data_in    in   24     {Ys, Us, Vs}, each byte component-128
//   pixel_in_valid   in   1      input pixel valid
//   pixel_in_ready   out  1      block accepts a pixel this cycle
//   pixel_data_out   out  24     {R, G, B}
//   pixel_out_valid  out  1      output pixel valid
//   pixel_out_ready  in   1      downstream accepts the output pixel
//   clip_cnt_clr     in   1      synchronous clear of clip_cnt
//   clip_cnt         out  CNT_W  saturating count of clipped components
module yuv2rgb
    import jpeg_color_pkg::*;
#(
    // The coefficients are fixed at x1024; FRAC_BITS only sets the shift
    // and rounding constant, so leave it at 10 unless they are rescaled.
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      pixel_data_in,
    input  logic             pixel_in_valid,
    output logic             pixel_in_ready,
    output logic [23:0]      pixel_data_out,
    output logic             pixel_out_valid,
    input  logic             pixel_out_ready,
    input  logic             clip_cnt_clr,
    output logic [CNT_W-1:0] clip_cnt
);

    localparam sum_t CRV_S = sum_t'(CRV);
    localparam sum_t CGU_S = sum_t'(CGU);
    localparam sum_t CGV_S = sum_t'(CGV);
    localparam sum_t CBU_S = sum_t'(CBU);
    localparam sum_t RND   = sum_t'(1 << (FRAC_BITS - 1));

    // ------------------------------------------------------------------
    // Handshake: a stage advances when empty or when its successor does
    // ------------------------------------------------------------------
    logic v1_reg, v2_reg, v3_reg;
    logic adv1, adv2, adv3;
    logic xfer_in, xfer12, xfer23;

    assign adv3 = ~v3_reg | pixel_out_ready;
    assign adv2 = ~v2_reg | adv3;
    assign adv1 = ~v1_reg | adv2;

    assign pixel_in_ready = adv1;

    assign xfer_in = pixel_in_valid & adv1;
    assign xfer12  = v1_reg & adv2;
    assign xfer23  = v2_reg & adv3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            // A stage that advances takes whatever its predecessor holds,
            // including a bubble, which is how bubbles collapse on a stall.
            if (adv1) v1_reg <= pixel_in_valid;
            if (adv2) v2_reg <= v1_reg;
            if (adv3) v3_reg <= v2_reg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: decode and multiply
    // ------------------------------------------------------------------
    logic [7:0] y_u;
    sum_t       y_ext, u_s, v_s;
    prod_t      prod_next, prod_reg;

    always_comb begin
        y_u   = decode_y(pixel_data_in[23:16]);
        y_ext = {{(SUM_W-8){1'b0}}, y_u};
        u_s   = sext8(pixel_data_in[15:8]);
        v_s   = sext8(pixel_data_in[7:0]);

        prod_next.y_sh  = y_ext << FRAC_BITS;
        prod_next.crv_v = v_s * CRV_S;
        prod_next.cgu_u = u_s * CGU_S;
        prod_next.cgv_v = v_s * CGV_S;
        prod_next.cbu_u = u_s * CBU_S;
    end

    // Datapath registers carry no reset: their contents are qualified by
    // the stage valids, which are reset.
    always_ff @(posedge clk) begin
        if (xfer_in) prod_reg <= prod_next;
    end

    // ------------------------------------------------------------------
    // Stage 2: rounded channel sums, index 0=R, 1=G, 2=B
    // ------------------------------------------------------------------
    sum_t sum_next [3];
    sum_t sum_reg  [3];

    always_comb begin
        sum_next[0] = prod_reg.y_sh + prod_reg.crv_v + RND;
        sum_next[1] = prod_reg.y_sh - prod_reg.cgu_u - prod_reg.cgv_v + RND;
        sum_next[2] = prod_reg.y_sh + prod_reg.cbu_u + RND;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sum
            always_ff @(posedge clk) begin
                if (xfer12) sum_reg[gi] <= sum_next[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 3: shift, clamp, register output
    // ------------------------------------------------------------------
    logic [7:0] ch_pix  [3];
    logic       ch_clip [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_clip
            yuv_clip8 #(
                .FRAC_BITS (FRAC_BITS)
            ) u_clip (
                .sum     (sum_reg[gi]),
                .pix     (ch_pix[gi]),
                .clipped (ch_clip[gi])
            );
        end
    endgenerate

    logic [23:0] data_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg <= 24'h0;
        end else if (xfer23) begin
            data_out_reg <= {ch_pix[0], ch_pix[1], ch_pix[2]};
        end
    end

    assign pixel_data_out  = data_out_reg;
    assign pixel_out_valid = v3_reg;

    // ------------------------------------------------------------------
    // Clip counter: counted as each pixel moves into stage 3
    // ------------------------------------------------------------------
    logic [1:0]       n_clip;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] clip_cnt_reg, clip_cnt_next;

    always_comb begin
        n_clip  = {1'b0, ch_clip[0]} + {1'b0, ch_clip[1]} + {1'b0, ch_clip[2]};
        // One spare bit catches the carry so saturation is a single test
        cnt_sum = {1'b0, clip_cnt_reg} + {{(CNT_W-1){1'b0}}, n_clip};
        clip_cnt_next = clip_cnt_reg;
        if (clip_cnt_clr) begin
            clip_cnt_next = '0;
        end else if (xfer23) begin
            clip_cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) clip_cnt_reg <= '0;
        else     clip_cnt_reg <= clip_cnt_next;
    end

    assign clip_cnt = clip_cnt_reg;

endmodule

// File: tb/tb_yuv2rgb.sv
// tb_yuv2rgb
// Self-checking bench for yuv2rgb: table of known pixels with hand-derived
// results, backpressure, counter saturation/clear and mid-stream reset
// sequences, plus randomized traffic checked by a forked monitor against an
// arithmetic reference model and an expected-pixel queue.
module tb_yuv2rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_data_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [23:0] pixel_data_out;
    logic        pixel_out_valid;
    logic        pixel_out_ready;
    logic        clip_cnt_clr;
    logic [15:0] clip_cnt;

    always #5 clk = ~clk;

    yuv2rgb #(
        .FRAC_BITS (10),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_data_in   (pixel_data_in),
        .pixel_in_valid  (pixel_in_valid),
        .pixel_in_ready  (pixel_in_ready),
        .pixel_data_out  (pixel_data_out),
        .pixel_out_valid (pixel_out_valid),
        .pixel_out_ready (pixel_out_ready),
        .clip_cnt_clr    (clip_cnt_clr),
        .clip_cnt        (clip_cnt)
    );

    typedef struct {
        logic [23:0] din;
        logic [23:0] dout;
        int          clips;
    } vec_t;

    int          nvec = 0;
    int          nerr = 0;
    int          n_out = 0;     // pixels seen leaving the DUT
    int          clip_sum = 0;  // model clip total of accepted pixels
    logic [23:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (plain integer arithmetic) -------
    function automatic int floor_div1024(input int a);
        if (a >= 0) return a / 1024;
        return -((-a + 1023) / 1024);
    endfunction

    function automatic int clamp(input int x, inout int nclip);
        if (x < 0)   begin nclip++; return 0;   end
        if (x > 255) begin nclip++; return 255; end
        return x;
    endfunction

    task automatic model(input logic [23:0] d, output logic [23:0] rgb, output int nclip);
        int ys, y, u, v, r, g, b;
        ys = $signed(d[23:16]);
        y  = ys + 128;
        u  = $signed(d[15:8]);
        v  = $signed(d[7:0]);
        nclip = 0;
        r = clamp(floor_div1024(1024 * y + 1613 * v + 512), nclip);
        g = clamp(floor_div1024(1024 * y - 192 * u - 479 * v + 512), nclip);
        b = clamp(floor_div1024(1024 * y + 1900 * u + 512), nclip);
        rgb = {r[7:0], g[7:0], b[7:0]};
    endtask

    // ---------------- monitor: scoreboard + stall stability ------------
    task automatic monitor();
        logic        prev_stall = 1'b0;
        logic [23:0] prev_data  = 24'h0;
        logic [23:0] exp_rgb, got;
        int          nc;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", {31'd0, pixel_out_valid}, 32'd1);
                    check("stall_data_hold", {8'd0, pixel_data_out}, {8'd0, prev_data});
                end
                if (pixel_out_valid && pixel_out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {8'd0, pixel_data_out}, 32'hFFFFFFFF);
                    end else begin
                        got = exp_q.pop_front();
                        $display("out pixel %06h expected %06h", pixel_data_out, got);
                        check("pixel_out", {8'd0, pixel_data_out}, {8'd0, got});
                    end
                end
                if (pixel_in_valid && pixel_in_ready) begin
                    model(pixel_data_in, exp_rgb, nc);
                    exp_q.push_back(exp_rgb);
                    clip_sum += nc;
                end
                prev_stall = pixel_out_valid && !pixel_out_ready;
                prev_data  = pixel_data_out;
            end
        end
    endtask

    task automatic drain();
        pixel_in_valid  = 1'b0;
        pixel_out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pulse_clr();
        clip_cnt_clr = 1'b1;
        tick();
        clip_cnt_clr = 1'b0;
    endtask

    // single pixel, measures latency from acceptance to pixel_out_valid
    task automatic one_pixel(input logic [23:0] d, output int lat);
        pixel_in_valid = 1'b1;
        pixel_data_in  = d;
        tick();
        pixel_in_valid = 1'b0;
        lat = 1;
        while (!pixel_out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    vec_t        tbl [7];
    logic [23:0] bp_pix [6];

    initial begin
        int lat, exp_clip, base, idx, out0, n;
        logic acc;

        tbl[0] = '{24'h000000, 24'h808080, 0};
        tbl[1] = '{24'h7F0000, 24'hFFFFFF, 0};
        tbl[2] = '{24'h800000, 24'h000000, 0};
        tbl[3] = '{24'hB6E27F, 24'hFE0000, 1};
        tbl[4] = '{24'h7F007F, 24'hFFC4FF, 1};
        tbl[5] = '{24'h7F7F7F, 24'hFFACFF, 2};
        tbl[6] = '{24'h808080, 24'h005400, 2};

        rst             = 1'b1;
        pixel_data_in   = 24'h0;
        pixel_in_valid  = 1'b0;
        pixel_out_ready = 1'b1;
        clip_cnt_clr    = 1'b0;

        fork
            monitor();
        join_none

        repeat (2) tick();
        check("rst_out_valid", {31'd0, pixel_out_valid}, 32'd0);
        check("rst_data_out", {8'd0, pixel_data_out}, 32'd0);
        check("rst_clip_cnt", {16'd0, clip_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, pixel_in_ready}, 32'd1);
        rst = 1'b0;

        // ---- table of known pixels, one at a time ----
        exp_clip = 0;
        for (int i = 0; i < 7; i++) begin
            exp_clip += tbl[i].clips;
            one_pixel(tbl[i].din, lat);
            $display("vec %0d in %06h out %06h clip_cnt %0d latency %0d",
                     i, tbl[i].din, pixel_data_out, clip_cnt, lat);
            check("tbl_latency", lat, 3);
            check("tbl_data", {8'd0, pixel_data_out}, {8'd0, tbl[i].dout});
            check("tbl_clip_cnt", {16'd0, clip_cnt}, exp_clip);
        end
        drain();

        // ---- grey and extremes back-to-back, no clips expected ----
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            pixel_in_valid = 1'b1;
            pixel_data_in  = tbl[i].din;
            tick();
        end
        drain();
        check("stream_clip_zero", {16'd0, clip_cnt}, 32'd0);

        // ---- backpressure: out_ready low for cycles 4..9 ----
        for (int i = 0; i < 6; i++) bp_pix[i] = {8'(16 * i + 5), 8'(i * 7), 8'(8'hF0 - i)};
        out0 = n_out;
        idx  = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx >= 6 && n_out - out0 >= 6) break;
            pixel_out_ready = !(c >= 4 && c <= 9);
            pixel_in_valid  = (idx < 6);
            if (idx < 6) pixel_data_in = bp_pix[idx];
            #1;
            acc = pixel_in_valid && pixel_in_ready;
            if (c >= 4 && c <= 9) check("bp_in_ready_low", {31'd0, pixel_in_ready}, 32'd0);
            tick();
            if (acc) idx++;
        end
        drain();
        check("bp_all_accepted", idx, 6);
        check("bp_all_out", n_out - out0, 6);

        // ---- randomized traffic ----
        pulse_clr();
        base = clip_sum;
        for (int c = 0; c < 400; c++) begin
            pixel_in_valid  = ($urandom_range(3) != 0);
            pixel_data_in   = 24'($urandom);
            pixel_out_ready = ($urandom_range(3) != 0);
            tick();
        end
        drain();
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_clip_cnt", {16'd0, clip_cnt}, clip_sum - base);

        // ---- saturation and clear ----
        pulse_clr();
        pixel_in_valid  = 1'b1;
        pixel_data_in   = 24'h7F7F7F;
        pixel_out_ready = 1'b1;
        n = 0;
        while (clip_cnt != 16'hFFFF && n < 40000) begin
            tick();
            n++;
        end
        check("sat_reached", {16'd0, clip_cnt}, 32'hFFFF);
        repeat (5) tick();
        check("sat_hold", {16'd0, clip_cnt}, 32'hFFFF);
        clip_cnt_clr = 1'b1;
        tick();
        clip_cnt_clr = 1'b0;
        check("clr_priority", {16'd0, clip_cnt}, 32'd0);
        tick();
        check("count_after_clr", {16'd0, clip_cnt}, 32'd2);
        drain();

        // ---- reset with 3 pixels in flight ----
        pixel_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pixel_in_valid = 1'b1;
            pixel_data_in  = 24'h7F7F7F;
            tick();
        end
        pixel_in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, pixel_out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, pixel_out_valid}, 32'd0);
        check("midrst_data_out", {8'd0, pixel_data_out}, 32'd0);
        check("midrst_clip_cnt", {16'd0, clip_cnt}, 32'd0);
        pixel_out_ready = 1'b1;
        one_pixel(24'h000000, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", {8'd0, pixel_data_out}, 32'h808080);
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
